dmem_responder: RTL and testbench

//  Data-memory responder for the CPU MEM stage: receives chip-select, per-byte write

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_responder_sram.sv | 23 ++
 rtl/dmem_responder.sv | 89 ++++++++
 tb/tb_dmem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default geometry for the data-memory responder
package dmem_pkg;
  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 32;
  localparam int BYTES = DMEM_DATA_W / 8;
  typedef enum logic {IDLE, BUSY} dmem_state_e;
  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] din;
    logic [BYTES-1:0]       we;
  } dmem_req_t;
endpackage

// File: rtl/dmem_responder_sram.sv
// sram_byte_array: single-port byte-writable array with a registered read port
module sram_byte_array #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      if (i_we == '0) r_rdata <= r_mem[i_addr];
    end
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with optional wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cs,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_din,
  output logic                o_ready,
  output logic [DATA_W-1:0]   o_dout,
  output logic                o_dout_valid
);
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
    logic [DATA_W/8-1:0] we;
  } req_t;
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be 0..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("dmem_responder: DATA_W must be a multiple of 8");
  end
  localparam logic [3:0] WAIT4 = 4'(WAIT_CYCLES);
  dmem_state_e       r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  req_t              r_req, w_live, w_acc;
  logic              w_accept, w_fire, w_rd_fire;
  logic              r_dout_valid, r_have;
  logic [DATA_W-1:0] w_rdata;
  assign w_live    = '{addr: i_addr, din: i_din, we: i_we};
  assign o_ready   = (r_state == IDLE);
  assign w_accept  = i_cs && o_ready;
  assign w_rd_fire = w_fire && (w_acc.we == '0);
  // Zero wait states hit the array on the accept edge straight from the ports
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_acc       = r_req;
    if (r_state == IDLE) begin
      if (w_accept && WAIT_CYCLES == 0) begin
        w_fire = 1'b1;
        w_acc  = w_live;
      end else if (w_accept) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = WAIT4;
      end
    end else begin
      w_cnt_nxt = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_fire      = 1'b1;
        w_state_nxt = IDLE;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req        <= '0;
      r_dout_valid <= 1'b0;
      r_have       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout_valid <= w_rd_fire;
      if (w_accept) r_req <= w_live;
      if (w_rd_fire) r_have <= 1'b1;
    end
  end
  sram_byte_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_fire),
    .i_we    (w_acc.we),
    .i_addr  (w_acc.addr),
    .i_wdata (w_acc.din),
    .o_rdata (w_rdata)
  );
  // The array read register has no reset, so dout stays zero until a read lands
  assign o_dout       = r_have ? w_rdata : '0;
  assign o_dout_valid = r_dout_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks a zero-wait and a three-wait responder against a word-level memory model
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_q [2];
  logic [3:0]  we_q [2];
  logic [13:0] addr_q [2];
  logic [31:0] din_q [2];
  logic        rdy [2];
  logic [31:0] dout [2];
  logic        dv [2];
  logic [31:0] mdl [int];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(14), .DATA_W(32), .WAIT_CYCLES(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs_q[0]), .i_we(we_q[0]), .i_addr(addr_q[0]),
    .i_din(din_q[0]), .o_ready(rdy[0]), .o_dout(dout[0]), .o_dout_valid(dv[0]));
  dmem_responder #(.ADDR_W(14), .DATA_W(32), .WAIT_CYCLES(3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs_q[1]), .i_we(we_q[1]), .i_addr(addr_q[1]),
    .i_din(din_q[1]), .o_ready(rdy[1]), .o_dout(dout[1]), .o_dout_valid(dv[1]));

  typedef struct {
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; issues one request and checks its timing and data
  task automatic req(input int k, input logic [3:0] w, input logic [13:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input bit hold);
    int wt = (k == 1) ? 3 : 0;
    int n = 0;
    int key = k * 65536 + int'(a);
    logic [31:0] v;
    cs_q[k] = 1'b1; we_q[k] = w; addr_q[k] = a; din_q[k] = d;
    while (!rdy[k] && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, rdy[k]}, 32'd1);
    tick();
    if (!hold) cs_q[k] = 1'b0;
    if (w != 4'h0) begin
      v = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (w[b]) v[8*b +: 8] = d[8*b +: 8];
      mdl[key] = v;
    end
    for (int i = 0; i <= wt + 1; i++) begin
      if (i > 0) tick();
      chk("dout_valid", {31'd0, dv[k]}, {31'd0, (w == 4'h0) && (i == wt)});
      if (i <= wt) chk("ready", {31'd0, rdy[k]}, {31'd0, i == wt});
      if (w == 4'h0 && i == wt) chk("dout", dout[k], exp);
      if (i == wt) cs_q[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cs_q[k] = 1'b0; we_q[k] = 4'h0; addr_q[k] = '0; din_q[k] = '0;
    end
    tbl[0]  = '{4'hF, 14'h010,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{4'h0, 14'h010,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{4'hF, 14'h020,  32'h11223344, 32'h0};
    tbl[3]  = '{4'h5, 14'h020,  32'hAABBCCDD, 32'h0};
    tbl[4]  = '{4'h0, 14'h020,  32'h0,        32'h11BB33DD};
    tbl[5]  = '{4'hF, 14'h3FFF, 32'h12345678, 32'h0};
    tbl[6]  = '{4'hF, 14'h000,  32'hA5A5A5A5, 32'h0};
    tbl[7]  = '{4'h0, 14'h3FFF, 32'h0,        32'h12345678};
    tbl[8]  = '{4'h0, 14'h000,  32'h0,        32'hA5A5A5A5};
    tbl[9]  = '{4'h2, 14'h020,  32'h0000EE00, 32'h0};
    tbl[10] = '{4'h0, 14'h020,  32'h0,        32'h11BBEEDD};
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {31'd0, rdy[k]}, 32'd1);
      chk("rst_dout", dout[k], 32'h0);
      chk("rst_dv", {31'd0, dv[k]}, 32'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 11; i++)
        req(k, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].exp, 1'b0);

    // Back-to-back on the zero-wait instance
    cs_q[0] = 1'b1; we_q[0] = 4'hF; addr_q[0] = 14'd5; din_q[0] = 32'h00000055;
    tick();
    mdl[5] = 32'h00000055;
    chk("b2b_wr_dv", {31'd0, dv[0]}, 32'd0);
    we_q[0] = 4'h0;
    tick();
    chk("b2b_raw_dv", {31'd0, dv[0]}, 32'd1);
    chk("b2b_raw", dout[0], 32'h00000055);
    for (int i = 0; i < 4; i++) begin
      addr_q[0] = i[0] ? 14'h3FFF : 14'h0;
      tick();
      chk("b2b_alt_dv", {31'd0, dv[0]}, 32'd1);
      chk("b2b_alt", dout[0], i[0] ? 32'h12345678 : 32'hA5A5A5A5);
    end
    cs_q[0] = 1'b0;
    tick();
    chk("b2b_end_dv", {31'd0, dv[0]}, 32'd0);

    // Held chip select during BUSY must not cause a second access
    req(1, 4'h0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b1);
    tick();
    chk("hold_no_extra_dv", {31'd0, dv[1]}, 32'd0);

    // Reset while a write is pending in the wait states
    req(1, 4'hF, 14'd7, 32'h0, 32'h0, 1'b0);
    cs_q[1] = 1'b1; we_q[1] = 4'hF; addr_q[1] = 14'd7; din_q[1] = 32'hCAFEF00D;
    chk("busy_pre_ready", {31'd0, rdy[1]}, 32'd1);
    tick();
    cs_q[1] = 1'b0;
    chk("busy_ready", {31'd0, rdy[1]}, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("midrst_dout", dout[1], 32'h0);
    chk("midrst_dv", {31'd0, dv[1]}, 32'd0);
    chk("midrst_dout0", dout[0], 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    req(1, 4'h0, 14'd7, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against the word-level model
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 120; n++) begin
        int r = $urandom_range(0, 9);
        logic [13:0] a = (r < 8) ? 14'(r) : (r == 8 ? 14'h3FFF : 14'($urandom));
        int key = k * 65536 + int'(a);
        logic [3:0] w = mdl.exists(key) ? (($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom)) : 4'hF;
        logic [31:0] exp = mdl.exists(key) ? mdl[key] : 32'h0;
        req(k, w, a, $urandom, exp, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) tick();
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
